alu_req_ctrl: RTL
=================

ALU_REQ_CTRL -- requirements
Module: alu_req_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, response FIFO entries; power of two, minimum 2.
REQ-002 Parameter TAG_W, default 4, width of the command tag carried through to the response.
REQ-003 Port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset; asynchronous assert, active-low.
REQ-005 Port cmd_valid / cmd_ready, input / output, 1 bit each, command handshake; transfer when both are high at a clk edge.
REQ-006 Port cmd_op, input, 3 bits, operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-007 Port cmd_a / cmd_b, input, 8 bits each, operands.
REQ-008 Port cmd_tag, input, TAG_W bits, caller tag.
REQ-009 Port alu_a / alu_b, output, 8 bits each, operands driven to the registered ALU.
REQ-010 Port alu_op, output, 3 bits, operation code driven to the ALU.
REQ-011 Port alu_result / alu_overflow, input, 9 bits / 1 bit, ALU outputs; valid one clk edge after the inputs are presented.
REQ-012 Port rsp_valid / rsp_ready, output / input, 1 bit each, response handshake.
REQ-013 Port rsp_result / rsp_overflow / rsp_err, output, 9 / 1 / 1 bits, response payload.
REQ-014 Port rsp_tag, output, TAG_W bits, tag of the originating command.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and CAPTURE, with reset state IDLE.
REQ-016 cmd_ready SHALL be high only in IDLE and only when FIFO occupancy is below DEPTH.
REQ-017 On acceptance in IDLE, the block SHALL register cmd_a, cmd_b, cmd_op and cmd_tag onto alu_a/alu_b/alu_op and an internal tag register, and move to ISSUE.
REQ-018 ISSUE SHALL last exactly one cycle with the ALU inputs held, then move to CAPTURE.
REQ-019 In CAPTURE, the block SHALL push {alu_result, alu_overflow, tag, err} into the FIFO at the clk edge ending the state, then return to IDLE.
REQ-020 When outside ISSUE, alu_op SHALL be driven to 3'b111 and alu_a/alu_b to 0.
REQ-021 Latency from command acceptance edge N to the FIFO write SHALL be edge N+2, with rsp_valid high from cycle N+2 if the FIFO was empty; sustained throughput SHALL be one command per 3 cycles.
REQ-022 For cmd_op 101–111, the block SHALL still issue the command, and the response SHALL carry rsp_err=1, rsp_result=0 and rsp_overflow=0.
REQ-023 ALU result and overflow SHALL pass through unmodified, with no re-computation or width change.
REQ-024 The FIFO SHALL deliver responses in command order and present a first-word-fall-through head; a pop occurs when rsp_valid and rsp_ready are both high.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged, and a push while full SHALL be impossible by construction (REQ-016 plus the single-command in-flight limit).
REQ-026 Pointer wrap-around SHALL be modulo DEPTH, with the full/empty distinction kept by an extra pointer bit.
REQ-027 rsp_valid SHALL stay high with a stable payload until popped.

Reset
REQ-028 Asserting rst_n low, including mid-command, SHALL abort any in-flight command without producing a response and flush the FIFO.
REQ-029 Reset values SHALL be: state IDLE; cmd_ready 0 while in reset; rsp_valid 0; rsp_result, rsp_overflow, rsp_err and rsp_tag all 0; alu_a and alu_b 0; alu_op 3'b111.
REQ-030 cmd_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro ALU_REQ_CTRL_STATS_EN SHALL control statistics support.
REQ-032 With the macro defined: add output ports stat_cmd_cnt[15:0], counting accepted commands, and stat_ovf_cnt[15:0], counting pushed responses with overflow=1; both SHALL be saturating at 16'hFFFF and reset to 0.
REQ-033 With the macro undefined: the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package alu_pkg SHALL hold the alu_op_e enum (ADD, SUB, AND, OR, XOR, NOP=3'b111), the operand width 8, the result width 9, and the response struct typedef.
REQ-035 Sub-module alu_rsp_fifo SHALL be a parameterised FIFO (DEPTH, payload width) instantiated once.

Verification
REQ-036 ADD: a=200, b=100, tag=3 -> response result=9'h12C, overflow=0, tag=3, err=0, two edges after acceptance.
REQ-037 SUB: a=5, b=10 -> result=9'h1FB, overflow=1; AND: a=8'hF0, b=8'h3C -> result=9'h030, overflow=0.
REQ-038 op=3'b110 -> err=1, result=0, overflow=0, and the response is still produced in order.
REQ-039 Back-pressure: rsp_ready=0 with 5 commands sent at DEPTH=4 -> cmd_ready drops after 4 responses; then, with rsp_ready=1, tags drain in order 0..3 and the 5th command completes.
REQ-040 Reset asserted during ISSUE -> no response produced, rsp_valid=0, alu_op=3'b111, and cmd_ready=1 in the first cycle after release.
REQ-041 With ALU_REQ_CTRL_STATS_EN: 3 commands, 1 of them overflowing -> stat_cmd_cnt=3 and stat_ovf_cnt=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes, FSM states and response payload type
package alu_pkg;
  localparam int OPND_W = 8;
  localparam int RES_W = 9;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOP = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_e;
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic overflow;
    logic err;
  } rsp_s;
  function automatic logic op_is_err(input logic [2:0] op);
    return op > ALU_XOR;
  endfunction
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: first-word-fall-through response FIFO; pointers carry an extra wrap bit
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  assign valid = wr_q != rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = valid ? mem_q[rd_q[AW-1:0]] : '0;
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop && valid};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: issues one command at a time to a registered ALU and queues tagged responses
// Optional statistics counters enabled by defining ALU_REQ_CTRL_STATS_EN.
module alu_req_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_cmd_cnt,
  output logic [15:0]       stat_ovf_cnt
`endif
);
  localparam int PW = TAG_W + $bits(rsp_s);
  state_e state_q, state_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic err_q, err_d, full, accept, push;
  rsp_s rsp_in, rsp_out;
  logic [PW-1:0] fifo_out;
  assign accept = cmd_valid && cmd_ready;
  assign push = state_q == ST_CAPTURE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ST_IDLE  ? (accept ? ST_ISSUE : ST_IDLE) :
              state_q == ST_ISSUE ? ST_CAPTURE : ST_IDLE;
  end
  always_comb begin
    cmd_ready = rst_n && state_q == ST_IDLE && !full;
    alu_a = a_q;
    alu_b = b_q;
    alu_op = op_q;
  end
  // Operand registers self-clear after ISSUE, so the ALU only sees a command for one cycle
  always_comb begin
    a_d = accept ? cmd_a : '0;
    b_d = accept ? cmd_b : '0;
    op_d = accept ? cmd_op : ALU_NOP;
    tag_d = accept ? cmd_tag : tag_q;
    err_d = accept ? op_is_err(cmd_op) : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= ALU_NOP;
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    rsp_in.result = err_q ? '0 : alu_result;
    rsp_in.overflow = !err_q && alu_overflow;
    rsp_in.err = err_q;
  end
  alu_rsp_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din({tag_q, rsp_in}),
    .pop(rsp_ready),
    .dout(fifo_out),
    .valid(rsp_valid),
    .full(full)
  );
  assign {rsp_tag, rsp_out} = fifo_out;
  assign rsp_result = rsp_out.result;
  assign rsp_overflow = rsp_out.overflow;
  assign rsp_err = rsp_out.err;
`ifdef ALU_REQ_CTRL_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d, ovf_cnt_q, ovf_cnt_d;
  always_comb begin
    cmd_cnt_d = cmd_cnt_q + {15'd0, accept && cmd_cnt_q != 16'hFFFF};
    ovf_cnt_d = ovf_cnt_q + {15'd0, push && rsp_in.overflow && ovf_cnt_q != 16'hFFFF};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
  assign stat_cmd_cnt = cmd_cnt_q;
  assign stat_ovf_cnt = ovf_cnt_q;
`endif
endmodule
